// File: rtl/mode_select_if.sv
// ---------------------------------------------------------------------------
// mode_select_if
// Groups the LED mode front-end signals into one bundle.
//   sw_raw     : raw slide switches (asynchronous to clk)
//   btn_raw    : raw push button, active-high (asynchronous to clk)
//   mode       : selected LED mode, 00 OFF / 01 BLINK / 10 COUNTER / 11 KNIGHT
//   mode_pulse : one-cycle strobe after mode takes a different value
//   dbg_state  : button FSM state for ILA debug (0 IDLE, 1 PRESSED, 2 WAIT_REL)
// master: the side that drives the raw inputs and consumes the mode.
// slave : the mode_select block itself.
// ---------------------------------------------------------------------------
interface mode_select_if;
    logic [1:0] sw_raw;
    logic       btn_raw;
    logic [1:0] mode;
    logic       mode_pulse;
    logic [1:0] dbg_state;

    modport master (
        output sw_raw,
        output btn_raw,
        input  mode,
        input  mode_pulse,
        input  dbg_state
    );

    modport slave (
        input  sw_raw,
        input  btn_raw,
        output mode,
        output mode_pulse,
        output dbg_state
    );
endinterface

// File: rtl/mode_select.sv
// ---------------------------------------------------------------------------
// mode_select
// Front-end producing the 2-bit LED mode code from two slide switches and a
// push button. Every raw input is 2-FF synchronised and debounced. A change
// of the debounced switch vector loads the mode directly, a short button
// press steps the mode (wrapping 11->00), a long press forces mode OFF.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : mode_select_if.slave (sw_raw, btn_raw in; mode, mode_pulse,
//           dbg_state out)
// ---------------------------------------------------------------------------
module mode_select #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    mode_select_if.slave bus
);

    localparam int              DB_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     HOLD_LIMIT = 32'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    // Bit 2 is the button, bits 1:0 are the switches.
    logic [2:0] raw_vec;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] stable_vec;

    assign raw_vec = {bus.btn_raw, bus.sw_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_vec;
            sync2_q <= sync1_q;
        end
    end

    // One debouncer per synchronised bit. The stable value only moves after
    // DEBOUNCE_CYCLES consecutive edges of disagreement.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_db
            logic [DB_W-1:0] cnt_q;
            logic            stable_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (sync2_q[gi] == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    stable_q <= sync2_q[gi];
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign stable_vec[gi] = stable_q;
        end
    endgenerate

    logic [1:0] sw_stable;
    logic       btn_stable;
    logic [1:0] sw_prev_q;
    logic       btn_prev_q;
    logic       sw_change;
    logic       btn_rise;

    assign sw_stable  = stable_vec[1:0];
    assign btn_stable = stable_vec[2];
    assign sw_change  = (sw_stable != sw_prev_q);
    assign btn_rise   = btn_stable & ~btn_prev_q;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        short_press;
    logic        long_press;
    logic [1:0]  mode_q, mode_d;
    logic        pulse_q, pulse_d;

    // State register plus the registers that follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            sw_prev_q  <= '0;
            btn_prev_q <= 1'b0;
            mode_q     <= 2'b00;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            sw_prev_q  <= sw_stable;
            btn_prev_q <= btn_stable;
            mode_q     <= mode_d;
            pulse_q    <= pulse_d;
        end
    end

    // Next-state logic. A switch change while a press is pending abandons
    // the press: the FSM just waits for the release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_rise) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (sw_change)                state_d = ST_WAIT_REL;
                else if (!btn_stable)         state_d = ST_IDLE;
                else if (hold_q == HOLD_LIMIT) state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!btn_stable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: press classification and the saturating hold counter.
    always_comb begin
        short_press = 1'b0;
        long_press  = 1'b0;
        hold_d      = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_rise) hold_d = '0;
            end
            ST_PRESSED: begin
                if (!sw_change) begin
                    if (!btn_stable)               short_press = 1'b1;
                    else if (hold_q == HOLD_LIMIT) long_press  = 1'b1;
                end
                if (hold_q != 32'hFFFF_FFFF) hold_d = hold_q + 32'd1;
            end
            default: ;
        endcase
    end

    // Mode update: switch load has priority over any button action.
    always_comb begin
        mode_d = mode_q;
        if (sw_change)        mode_d = sw_stable;
        else if (short_press) mode_d = mode_q + 2'b01;
        else if (long_press)  mode_d = 2'b00;
        pulse_d = (mode_d != mode_q);
    end

    assign bus.mode       = mode_q;
    assign bus.mode_pulse = pulse_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/mode_select.md
Name: mode_select

Overview:
- Upstream front-end for the LED top-level mode input; it produces the 2-bit mode code that drives the LED mode multiplexer.
- Synchronises and debounces two raw slide switches and one push button.
- A switch change loads the mode directly. A short button press steps the mode. A long button press forces mode OFF (00).
- Provides a one-cycle change strobe and FSM state for ILA debug.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronised input must differ from its stable value before it is accepted (10 ms at 100 MHz); legal range ≥2.
- HOLD_CYCLES, 100_000_000, cycles the stable button must stay high to count as a long press (1 s at 100 MHz); must exceed DEBOUNCE_CYCLES.

Ports:
- clk  input  1  100 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  2  raw slide switches, asynchronous to clk.
- btn_raw  input  1  raw push button, active-high, asynchronous to clk.
- mode  output  2  selected mode: 00 OFF, 01 BLINK, 10 COUNTER, 11 KNIGHT.
- mode_pulse  output  1  one-cycle strobe when mode takes a different value.
- dbg_state  output  2  button FSM state: 0 IDLE, 1 PRESSED, 2 WAIT_REL.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Clears all sync flops, stable values, counters, mode (00) and mode_pulse (0).
  - FSM goes to IDLE.
  - Reset mid-press or mid-debounce discards all progress.
- Synchronisers: 2-FF synchroniser per bit (sw_raw[1:0], btn_raw).
- Debouncers: one per synchronised bit, each with its own counter sized ceil(log2(DEBOUNCE_CYCLES)).
  - Synced value equals stable value: counter cleared.
  - Synced value differs: counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, stable takes the synced value and the counter clears.
  - Any shorter glitch is ignored and the counter restarts from 0.
- Latency: raw edge to stable change is 2 + DEBOUNCE_CYCLES edges (+1 for asynchronous sampling). Stable change to mode update is 1 edge.
- Switch path: when the stable 2-bit switch vector differs from its previous-cycle value, mode <= new stable switch vector on the next edge.
- Button FSM:
  - IDLE: stable button rises -> PRESSED and clear the hold counter.
  - PRESSED, stable button falls before the hold counter reaches HOLD_CYCLES-1 (short press): mode <= mode+1, wrapping 11->00; -> IDLE.
  - PRESSED, hold counter reaches HOLD_CYCLES-1 with the button still high (long press): mode <= 00; -> WAIT_REL.
  - WAIT_REL: stable button falls -> IDLE; no mode action.
  - Hold counter is 32 bits, increments only in PRESSED, and saturates.
- Simultaneous events and aborts:
  - A switch-vector change in the same cycle as a button mode action: the switch value wins and the button action is dropped.
  - A switch change while in PRESSED sends the FSM to WAIT_REL, so the pending press is abandoned and its release does nothing.
- mode_pulse:
  - Registered; high for exactly the cycle after mode changed value.
  - No pulse if the new value equals the old one (e.g. switch loads the current mode; long press while already 00).
- mode is registered and glitch-free, so it can drive the mode multiplexer directly.
- dbg_state is the registered FSM state encoding.

Test Plan:
(All directed tests use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.)
1. Reset, then hold all inputs 0 for 50 cycles -> mode=00, mode_pulse never asserted, dbg_state=0.
2. sw_raw 00->10, held -> mode=10 within 2+4+1(+1) edges, with exactly one mode_pulse. Then a 3-cycle glitch of sw_raw to 11 -> mode stays 10, no pulse.
3. Starting from mode 11, a btn_raw pulse of 10 cycles -> mode wraps to 00 after the release is debounced, one pulse; dbg_state sequence 0->1->0.
4. Starting from mode 01, hold btn_raw for 40 cycles -> mode=00 about 20 cycles after the stable rise, one pulse, dbg_state=2. Release -> dbg_state=0 and mode unchanged. Repeat starting at mode 00 -> no pulse.
5. Press btn_raw, change sw_raw to 01 while in PRESSED, then release -> mode=01 from the switch only; the release does not increment; FSM passes through WAIT_REL.
6. Assert rst_n low mid-press with mode=10 -> immediately mode=00, pulse=0, dbg_state=0. After release of reset with btn_raw still high -> a fresh press is recognised only after a full debounce.
